// File: rtl/ir_uart_pkg.sv
// Shared types and constants for the IR-command UART transmitter.
// The frame is the 12-byte ASCII text {"state":D}\n, where D is the command digit.
package ir_uart_pkg;

    localparam int unsigned MSG_LEN    = 12;
    localparam logic [3:0]  LAST_IDX   = 4'd11;
    localparam logic [3:0]  DIGIT_IDX  = 4'd9;
    localparam logic [7:0]  ASCII_ZERO = 8'h30;

    // Fixed frame text. Index 9 holds ASCII '0'; frame_byte substitutes the live digit there.
    localparam logic [7:0] FRAME_BYTES [0:MSG_LEN-1] = '{
        8'h7B, 8'h22, 8'h73, 8'h74, 8'h61, 8'h74,
        8'h65, 8'h22, 8'h3A, 8'h30, 8'h7D, 8'h0A
    };

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_LOAD   = 2'd1,
        M_SEND   = 2'd2,
        M_FINISH = 2'd3
    } msg_state_e;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_e;

    // Returns byte idx of the frame for command value v.
    // Out-of-range indices return the newline byte.
    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [2:0] v);
        logic [7:0] b;
        if (idx == DIGIT_IDX) begin
            b = ASCII_ZERO + {5'd0, v};
        end else if (idx <= LAST_IDX) begin
            b = FRAME_BYTES[idx];
        end else begin
            b = 8'h0A;
        end
        return b;
    endfunction

endpackage

// File: rtl/ir_cmd_uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit.
// Every bit lasts CLKS_PER_BIT cycles.
// byte_done is high on the last cycle of the stop bit. A start seen on that
// same cycle chains straight into the next start bit, so consecutive bytes
// have no idle gap between them.
module uart_tx_byte
    import ir_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done,
    output logic       tx_busy
);

    localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             bit_end_s;

    assign bit_end_s = (cnt_q == CNT_MAX);
    assign byte_done = (state_q == U_STOP) && bit_end_s;
    assign tx_busy   = (state_q != U_IDLE);
    assign tx        = tx_q;

    // Bit-timing FSM. The serial line is driven from a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= U_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                U_IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        state_q <= U_START;
                        shift_q <= data;
                        bit_q   <= 3'd0;
                        tx_q    <= 1'b0;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                U_START: begin
                    if (bit_end_s) begin
                        cnt_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= U_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                U_DATA: begin
                    if (bit_end_s) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= U_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                U_STOP: begin
                    if (bit_end_s) begin
                        cnt_q <= '0;
                        if (start) begin
                            state_q <= U_START;
                            shift_q <= data;
                            bit_q   <= 3'd0;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= U_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= U_IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ir_cmd_uart_tx.sv
// Sends {"state":D}\n over the UART whenever the IR command changes or a resend
// pulse arrives. Requests that arrive during a frame collapse into one pending
// retransmission, which starts right after the frame completes.
module ir_cmd_uart_tx
    import ir_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state_control,
    input  logic       resend,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    msg_state_e state_q;
    logic [3:0] idx_q;
    logic [2:0] last_sent_q;   // also the value frozen into the frame in flight
    logic       pending_q;
    logic       busy_q;
    logic       done_q;

    logic       trigger_s;
    logic       start_s;
    logic [7:0] byte_s;
    logic       byte_done_s;
    logic       tx_busy_s;

    assign trigger_s = (state_control != last_sent_q) || resend;
    assign busy      = busy_q;
    assign done      = done_q;

    // Select which byte to hand to the serialiser: the first byte from LOAD,
    // or the following byte chained onto the current byte's final stop cycle.
    always_comb begin
        start_s = 1'b0;
        byte_s  = frame_byte(idx_q, last_sent_q);
        if (state_q == M_LOAD) begin
            start_s = !tx_busy_s;
            byte_s  = frame_byte(idx_q, last_sent_q);
        end else if ((state_q == M_SEND) && byte_done_s && (idx_q != LAST_IDX)) begin
            start_s = 1'b1;
            byte_s  = frame_byte(idx_q + 4'd1, last_sent_q);
        end else begin
            start_s = 1'b0;
        end
    end

    // Message sequencer: snapshot the command, walk the 12 frame bytes, pulse done,
    // then either go idle or start the pending retransmission.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= M_IDLE;
            idx_q       <= 4'd0;
            last_sent_q <= 3'd0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                M_IDLE: begin
                    done_q <= 1'b0;
                    if (trigger_s) begin
                        last_sent_q <= state_control;
                        idx_q       <= 4'd0;
                        pending_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= M_LOAD;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                M_LOAD: begin
                    if (trigger_s) begin
                        pending_q <= 1'b1;
                    end
                    state_q <= M_SEND;
                end
                M_SEND: begin
                    if (trigger_s) begin
                        pending_q <= 1'b1;
                    end
                    if (byte_done_s) begin
                        if (idx_q == LAST_IDX) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= M_FINISH;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                M_FINISH: begin
                    done_q <= 1'b0;
                    if (pending_q || trigger_s) begin
                        pending_q   <= 1'b0;
                        last_sent_q <= state_control;
                        idx_q       <= 4'd0;
                        busy_q      <= 1'b1;
                        state_q     <= M_LOAD;
                    end else begin
                        state_q <= M_IDLE;
                    end
                end
                default: begin
                    state_q   <= M_IDLE;
                    pending_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s),
        .data     (byte_s),
        .tx       (tx),
        .byte_done(byte_done_s),
        .tx_busy  (tx_busy_s)
    );

endmodule

// File: tb/tb_ir_cmd_uart_tx.sv
// Directed bench for ir_cmd_uart_tx with CLKS_PER_BIT=4.
// Frames are captured cycle by cycle and decoded back to bytes; expected bytes
// come from a hand-written table.
module tb_ir_cmd_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 120 * CPB;

    logic       clk;
    logic       rst;
    logic [2:0] state_control;
    logic       resend;
    logic       tx;
    logic       busy;
    logic       done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic       txs   [0:FRAME_CYC-1];
    logic       busys [0:FRAME_CYC-1];
    logic       dones [0:FRAME_CYC-1];
    logic [7:0] dec_bytes [0:11];
    int timing_errs, start_errs, stop_errs, busy_drops, early_done;

    ir_cmd_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .state_control(state_control),
        .resend       (resend),
        .tx           (tx),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input int k, input logic [2:0] d);
        case (k)
            0: return 8'h7B;  1: return 8'h22;  2: return 8'h73;  3: return 8'h74;
            4: return 8'h61;  5: return 8'h74;  6: return 8'h65;  7: return 8'h22;
            8: return 8'h3A;  9: return 8'h30 + {5'd0, d};
            10: return 8'h7D; 11: return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    // Sample the line for one frame length, starting on the start-bit edge of byte 0.
    // With inject=1, a change to 2, a change to 4 and a resend pulse are applied mid-frame.
    task automatic record_frame(input int inject);
        for (int i = 0; i < FRAME_CYC; i++) begin
            txs[i] = tx; busys[i] = busy; dones[i] = done;
            if (inject == 1) begin
                if (i == 40)  state_control = 3'd2;
                if (i == 120) state_control = 3'd4;
                if (i == 200) resend = 1'b1;
                if (i == 201) resend = 1'b0;
            end
            tick();
        end
    endtask

    task automatic decode_frame();
        int base;
        timing_errs = 0; start_errs = 0; stop_errs = 0; busy_drops = 0; early_done = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (busys[i] !== 1'b1) busy_drops++;
            if (dones[i] !== 1'b0) early_done++;
        end
        for (int k = 0; k < 12; k++) begin
            base = k * 10 * CPB;
            for (int j = 0; j < 10; j++)
                for (int c = 1; c < CPB; c++)
                    if (txs[base + j*CPB + c] !== txs[base + j*CPB]) timing_errs++;
            if (txs[base] !== 1'b0) start_errs++;
            if (txs[base + 9*CPB] !== 1'b1) stop_errs++;
            for (int b = 0; b < 8; b++) dec_bytes[k][b] = txs[base + (b+1)*CPB + 1];
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; state_control = 3'd0; resend = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++; if (tx !== 1'b1)   begin tests_failed++; $display("FAIL reset_tx: got %b expected 1", tx); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tick(); tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int lows = 0, highs = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) highs++;
        end
        tests_run++; if (lows != 0)  begin tests_failed++; $display("FAIL idle_tx: %0d cycles not high, expected 0", lows); end
        tests_run++; if (highs != 0) begin tests_failed++; $display("FAIL idle_busy: %0d cycles busy, expected 0", highs); end
    endtask

    task automatic test_resend();
        resend = 1'b1; tick(); resend = 1'b0;
        tests_run++; if (busy !== 1'b1 || tx !== 1'b1) begin tests_failed++; $display("FAIL resend_accept: busy=%b tx=%b expected busy=1 tx=1", busy, tx); end
        tick();
        tests_run++; if (tx !== 1'b0) begin tests_failed++; $display("FAIL resend_start: tx=%b expected 0", tx); end
        record_frame(0); decode_frame();
        for (int k = 0; k < 12; k++) begin
            tests_run++; if (dec_bytes[k] !== exp_byte(k, 3'd0)) begin tests_failed++; $display("FAIL resend_byte%0d: got %02h expected %02h", k, dec_bytes[k], exp_byte(k, 3'd0)); end
        end
        tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL resend_done: done=%b busy=%b expected 1 0", done, busy); end
        tick();
        tests_run++; if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL resend_after: done=%b busy=%b expected 0 0", done, busy); end
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_frame();
        state_control = 3'd3; tick();
        tests_run++; if (busy !== 1'b1 || tx !== 1'b1) begin tests_failed++; $display("FAIL frame_accept: busy=%b tx=%b expected busy=1 tx=1", busy, tx); end
        tick();
        tests_run++; if (tx !== 1'b0) begin tests_failed++; $display("FAIL frame_start: tx=%b expected 0", tx); end
        record_frame(0); decode_frame();
        for (int k = 0; k < 12; k++) begin
            tests_run++; if (dec_bytes[k] !== exp_byte(k, 3'd3)) begin tests_failed++; $display("FAIL frame_byte%0d: got %02h expected %02h", k, dec_bytes[k], exp_byte(k, 3'd3)); end
        end
        tests_run++; if (timing_errs != 0) begin tests_failed++; $display("FAIL frame_timing: %0d off-grid samples, expected 0", timing_errs); end
        tests_run++; if (start_errs != 0)  begin tests_failed++; $display("FAIL frame_startbits: %0d bad, expected 0", start_errs); end
        tests_run++; if (stop_errs != 0)   begin tests_failed++; $display("FAIL frame_stopbits: %0d bad, expected 0", stop_errs); end
        tests_run++; if (busy_drops != 0)  begin tests_failed++; $display("FAIL frame_busy: %0d low cycles in frame, expected 0", busy_drops); end
        tests_run++; if (early_done != 0)  begin tests_failed++; $display("FAIL frame_early_done: %0d cycles, expected 0", early_done); end
        tests_run++; if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin tests_failed++; $display("FAIL frame_done: done=%b busy=%b tx=%b expected 1 0 1", done, busy, tx); end
        tick();
        tests_run++; if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL frame_after: done=%b busy=%b expected 0 0", done, busy); end
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_coalesce();
        int lows = 0, highs = 0;
        state_control = 3'd1; tick(); tick();
        tests_run++; if (tx !== 1'b0) begin tests_failed++; $display("FAIL coal_start: tx=%b expected 0", tx); end
        record_frame(1); decode_frame();
        tests_run++; if (dec_bytes[9] !== 8'h31) begin tests_failed++; $display("FAIL coal_frozen_digit: got %02h expected 31", dec_bytes[9]); end
        tests_run++; if (busy_drops != 0) begin tests_failed++; $display("FAIL coal_busy1: %0d low cycles, expected 0", busy_drops); end
        tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL coal_done1: done=%b busy=%b expected 1 0", done, busy); end
        tick();
        tests_run++; if (busy !== 1'b1 || done !== 1'b0 || tx !== 1'b1) begin tests_failed++; $display("FAIL coal_restart: busy=%b done=%b tx=%b expected 1 0 1", busy, done, tx); end
        tick();
        tests_run++; if (tx !== 1'b0) begin tests_failed++; $display("FAIL coal_start2: tx=%b expected 0", tx); end
        record_frame(0); decode_frame();
        for (int k = 0; k < 12; k++) begin
            tests_run++; if (dec_bytes[k] !== exp_byte(k, 3'd4)) begin tests_failed++; $display("FAIL coal_byte%0d: got %02h expected %02h", k, dec_bytes[k], exp_byte(k, 3'd4)); end
        end
        tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL coal_done2: done=%b busy=%b expected 1 0", done, busy); end
        for (int i = 0; i < 600; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) highs++;
        end
        tests_run++; if (lows != 0 || highs != 0) begin tests_failed++; $display("FAIL coal_no_third: tx low %0d busy %0d cycles, expected 0 0", lows, highs); end
    endtask

    task automatic test_reset_mid();
        int lows = 0, highs = 0;
        state_control = 3'd0; tick(); tick();
        for (int i = 0; i < 200; i++) tick();
        tests_run++; if (tx !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL mid_pre: tx=%b busy=%b expected 0 1", tx, busy); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL mid_async: tx=%b busy=%b done=%b expected 1 0 0", tx, busy, done); end
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0 || done !== 1'b0) highs++;
        end
        tests_run++; if (lows != 0 || highs != 0) begin tests_failed++; $display("FAIL mid_no_resume: tx low %0d busy/done %0d cycles, expected 0 0", lows, highs); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_resend();
        test_frame();
        test_coalesce();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ir_cmd_uart_tx.md
Name: ir_cmd_uart_tx

Overview:
- Downstream consumer of the IR command decoder's 3-bit state_control.
- Serialises each new command as a fixed 12-byte ASCII JSON frame `{"state":D}\n` over an 8N1 UART to the robot-side microcontroller.
- D is ASCII '0'+state_control.
- Transmits on any change of state_control, or on an explicit resend pulse; coalesces requests that arrive while a frame is in flight.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- MSG_LEN, 12, bytes per frame; fixed, not to be overridden.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous active-high reset
- state_control  input  3  command code from IR controller, synchronous to clk
- resend  input  1  single-cycle pulse; force retransmission of current state_control
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a frame is being transmitted
- done  output  1  one-cycle pulse on the cycle after the final stop bit of a frame

Behaviour:
- Reset values (async, immediate): tx=1, busy=0, done=0, last_sent=3'd0, pending=0, FSMs in IDLE.
- Trigger condition, evaluated every cycle: (state_control != last_sent) OR resend.
- IDLE, trigger seen at edge N:
  - Snapshot value V=state_control; last_sent<=V; busy<=1.
  - tx falls (start bit of byte 0) at edge N+1.
- Byte table, index 0..11: 0x7B 0x22 0x73 0x74 0x61 0x74 0x65 0x22 0x3A (0x30+V) 0x7D 0x0A.
- Each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); every bit held exactly CLKS_PER_BIT cycles.
- Bytes are back-to-back, no idle gap: start bit of byte k+1 begins the cycle after the stop bit of byte k ends.
- Frame length is exactly 120*CLKS_PER_BIT cycles from start-bit low to end of last stop bit.
- done pulses 1 cycle, busy falls on the same edge, tx=1.
- Trigger while busy:
  - Set pending; do not alter the frame in flight (V frozen).
  - Multiple triggers collapse into one pending flag.
- On the done cycle, if pending is set, or state_control != last_sent:
  - Clear pending, re-snapshot, start a new frame.
  - busy is re-asserted the next cycle (one-cycle busy-low gap).
- Resend with an unchanged value still sends a frame.
- A change that reverts to last_sent before IDLE samples it sends nothing. While busy, such a change sends the frame already marked pending.
- Reset mid-frame: tx returns high immediately, pending cleared. Any partial byte is abandoned, no completion frame.
- Message FSM states: IDLE → SEND (issue byte idx to sub-module, wait for its byte_done) → idx==11 ? FINISH : SEND with idx+1 → FINISH (done pulse) → IDLE or SEND.
- Bit counter width ceil(log2(CLKS_PER_BIT)); byte index 4 bits; data-bit index 3 bits.

Decomposition:
- Package ir_uart_pkg:
  - msg FSM enum
  - uart FSM enum {U_IDLE,U_START,U_DATA,U_STOP}
  - MSG_LEN
  - the 11 constant frame bytes as a localparam array, with the digit slot at index 9
  - ASCII_ZERO
- Sub-module uart_tx_byte (CLKS_PER_BIT):
  - inputs clk, rst, start, data[7:0]; outputs tx, byte_done, tx_busy.
  - Accepts start on the same cycle it raises byte_done, to achieve gapless bytes.

Test Plan (CLKS_PER_BIT=4):
- Reset then state_control 0→3 at cycle 10 → tx low at cycle 11; decoded bytes 7B 22 73 74 61 74 65 22 3A 33 7D 0A; done at cycle 11+480; busy high 480 cycles.
- state_control held 0 after reset, no resend → tx stays 1, busy 0 for 2000 cycles.
- resend pulse with state_control=0 → one frame with digit 0x30.
- During frame for 1: change to 2, then 4, plus a resend → after done, exactly one further frame with digit 0x34, then idle.
- Assert rst at cycle 200 of a frame → tx=1, busy=0 same cycle; after release with unchanged input, no transmission.
- Bit-timing check: each tx transition lands on a multiple of 4 cycles from the start edge; stop bits all 1.
